branch_direction_predictor: RTL and testbench

- Sits between the BTB and the fetch PC register.
- Holds a pattern history table (PHT) of 2-bit saturating counters and combines it with the BTB hit/BTA to pick the predicted next PC in Fetch.
- Carries each prediction through Decode and Execute, resolves it against the ALU branch outcome, and updates the PHT.
- Generates mispredict/redirect and drives branchPredictedE back to the BTB.

---
 rtl/branch_direction_predictor_pkg.sv | 35 +++
 rtl/branch_direction_predictor_if.sv | 33 +++
 rtl/branch_direction_predictor_pht.sv | 32 +++
 rtl/branch_direction_predictor.sv | 128 ++++++++++++
 tb/tb_branch_direction_predictor.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/branch_direction_predictor_pkg.sv
// Shared types and helpers for the branch direction predictor and its PHT.
package bp_pkg;

    localparam int PHT_W_IDX = 6;
    localparam int BP_W_STAT = 16;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // One in-flight prediction carried from Fetch through Decode to Execute.
    typedef struct packed {
        logic                 valid;
        logic                 pred_taken;
        logic [31:0]          pred_target;
        logic [PHT_W_IDX-1:0] idx;
        logic [31:0]          pc_plus4;
    } stage_rec_t;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken) begin
            if (cnt == ST) res = ST;
            else           res = cnt + 2'd1;
        end else begin
            if (cnt == SNT) res = SNT;
            else            res = cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_direction_predictor_if.sv
// Fetch/Decode/Execute-side signal bundle of the branch direction predictor.
interface branch_direction_predictor_if #(parameter int W_STAT = 16);
    logic [31:0]       pcF;
    logic              btbHit;
    logic [31:0]       btbBTA;
    logic              stallD;
    logic              flushD;
    logic              flushE;
    logic              branchE;
    logic              branchTakenE;
    logic [31:0]       aluBranchAddress;
    logic [31:0]       pcNextPred;
    logic              predictTakenF;
    logic              branchPredictedE;
    logic              mispredictE;
    logic [31:0]       redirectPC;
    logic [W_STAT-1:0] brCount;
    logic [W_STAT-1:0] mispCount;

    modport master (
        output pcF, btbHit, btbBTA, stallD, flushD, flushE,
               branchE, branchTakenE, aluBranchAddress,
        input  pcNextPred, predictTakenF, branchPredictedE,
               mispredictE, redirectPC, brCount, mispCount
    );

    modport slave (
        input  pcF, btbHit, btbBTA, stallD, flushD, flushE,
               branchE, branchTakenE, aluBranchAddress,
        output pcNextPred, predictTakenF, branchPredictedE,
               mispredictE, redirectPC, brCount, mispCount
    );
endinterface

// File: rtl/branch_direction_predictor_pht.sv
// Pattern history table: 2-bit saturating counters, combinational read, clocked update.
module branch_pht
    import bp_pkg::*;
#(
    parameter int W_IDX = PHT_W_IDX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W_IDX-1:0] rd_idx_i,
    output logic             rd_pred_o,
    input  logic             we_i,
    input  logic [W_IDX-1:0] wr_idx_i,
    input  logic             wr_taken_i
);
    localparam int N_ENT = 1 << W_IDX;

    logic [1:0] pht_q [N_ENT];

    // Read returns the pre-write value; an update becomes visible next cycle.
    assign rd_pred_o = pht_q[rd_idx_i][1];

    // Counter array: weakly not-taken on reset, saturating update on resolve.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_ENT; i++) begin
                pht_q[i] <= WNT;
            end
        end else if (we_i) begin
            pht_q[wr_idx_i] <= sat_update(pht_q[wr_idx_i], wr_taken_i);
        end
    end
endmodule

// File: rtl/branch_direction_predictor.sv
// Direction predictor: PHT lookup in Fetch, D/E prediction pipeline, resolution and statistics.
module branch_direction_predictor
    import bp_pkg::*;
#(
    parameter int W_IDX  = PHT_W_IDX,
    parameter int W_STAT = BP_W_STAT
) (
    input  logic                         clk,
    input  logic                         reset,
    branch_direction_predictor_if.slave  bp
);
    logic [W_IDX-1:0]  idx_f_s;
    logic              pht_pred_s;
    logic              pred_taken_f_s;
    logic [31:0]       pc_plus4_f_s;
    stage_rec_t        rec_f_s;
    stage_rec_t        rec_d_q, rec_d_d;
    stage_rec_t        rec_e_q, rec_e_d;
    logic              resolve_s;
    logic              misp_s;
    logic [31:0]       redirect_s;
    logic [W_STAT-1:0] br_cnt_q, br_cnt_d;
    logic [W_STAT-1:0] misp_cnt_q, misp_cnt_d;

    assign idx_f_s        = bp.pcF[W_IDX+1:2];
    assign pc_plus4_f_s   = bp.pcF + 32'd4;
    assign pred_taken_f_s = bp.btbHit & pht_pred_s;
    assign resolve_s      = rec_e_q.valid & bp.branchE;

    branch_pht #(.W_IDX(W_IDX)) u_pht (
        .clk        (clk),
        .reset      (reset),
        .rd_idx_i   (idx_f_s),
        .rd_pred_o  (pht_pred_s),
        .we_i       (resolve_s),
        .wr_idx_i   (W_IDX'(rec_e_q.idx)),
        .wr_taken_i (bp.branchTakenE)
    );

    // Fetch-stage record handed to the Decode register.
    always_comb begin
        rec_f_s             = '0;
        rec_f_s.valid       = 1'b1;
        rec_f_s.pred_taken  = pred_taken_f_s;
        rec_f_s.pred_target = bp.btbBTA;
        rec_f_s.idx         = PHT_W_IDX'(idx_f_s);
        rec_f_s.pc_plus4    = pc_plus4_f_s;
    end

    // Resolution; a non-branch predicted taken is a BTB alias and falls through.
    always_comb begin
        misp_s     = 1'b0;
        redirect_s = 32'd0;
        if (rec_e_q.valid) begin
            if (bp.branchE) begin
                misp_s = (bp.branchTakenE != rec_e_q.pred_taken) |
                         (bp.branchTakenE & rec_e_q.pred_taken &
                          (bp.aluBranchAddress != rec_e_q.pred_target));
            end else begin
                misp_s = rec_e_q.pred_taken;
            end
        end else begin
            misp_s = 1'b0;
        end
        if (misp_s) begin
            redirect_s = (bp.branchE & bp.branchTakenE) ? bp.aluBranchAddress : rec_e_q.pc_plus4;
        end else begin
            redirect_s = 32'd0;
        end
    end

    // Pipeline next state; a mispredict squashes both stages ahead of stall/flush.
    always_comb begin
        rec_d_d = rec_d_q;
        rec_e_d = rec_e_q;
        if (misp_s || bp.flushD) begin
            rec_d_d.valid = 1'b0;
        end else if (bp.stallD) begin
            rec_d_d = rec_d_q;
        end else begin
            rec_d_d = rec_f_s;
        end
        if (misp_s || bp.flushE) begin
            rec_e_d.valid = 1'b0;
        end else begin
            rec_e_d = rec_d_q;
        end
    end

    // Saturating statistics next state.
    always_comb begin
        br_cnt_d   = br_cnt_q;
        misp_cnt_d = misp_cnt_q;
        if (resolve_s && (br_cnt_q != '1)) begin
            br_cnt_d = br_cnt_q + W_STAT'(1);
        end else begin
            br_cnt_d = br_cnt_q;
        end
        if (misp_s && (misp_cnt_q != '1)) begin
            misp_cnt_d = misp_cnt_q + W_STAT'(1);
        end else begin
            misp_cnt_d = misp_cnt_q;
        end
    end

    // Stage and statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rec_d_q    <= '0;
            rec_e_q    <= '0;
            br_cnt_q   <= '0;
            misp_cnt_q <= '0;
        end else begin
            rec_d_q    <= rec_d_d;
            rec_e_q    <= rec_e_d;
            br_cnt_q   <= br_cnt_d;
            misp_cnt_q <= misp_cnt_d;
        end
    end

    assign bp.pcNextPred       = pred_taken_f_s ? bp.btbBTA : pc_plus4_f_s;
    assign bp.predictTakenF    = pred_taken_f_s;
    assign bp.branchPredictedE = rec_e_q.valid & rec_e_q.pred_taken;
    assign bp.mispredictE      = misp_s;
    assign bp.redirectPC       = redirect_s;
    assign bp.brCount          = br_cnt_q;
    assign bp.mispCount        = misp_cnt_q;
endmodule

// File: tb/tb_branch_direction_predictor.sv
// Scoreboard bench: driver pushes reference-model expectations, monitor compares each cycle.
module tb_branch_direction_predictor;

    logic clk;
    logic reset;

    branch_direction_predictor_if #(.W_STAT(16)) bif ();

    branch_direction_predictor #(.W_IDX(6), .W_STAT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] npc;
        logic        ptf;
        logic        bpe;
        logic        misp;
        logic [31:0] redir;
        logic [15:0] br;
        logic [15:0] msp;
    } exp_t;

    typedef struct {
        bit          v;
        bit          pt;
        logic [31:0] tgt;
        int          idx;
        logic [31:0] p4;
    } rec_t;

    exp_t        exp_q[$];
    int          checks;
    int          failures;

    // Reference model state: counter values 0..3, in-flight predictions, counts.
    int          pht_m[64];
    rec_t        md, me;
    int          br_m, msp_m;

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) pht_m[i] = 1;
        md    = '{1'b0, 1'b0, 32'd0, 0, 32'd0};
        me    = '{1'b0, 1'b0, 32'd0, 0, 32'd0};
        br_m  = 0;
        msp_m = 0;
    endfunction

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
        end
    endfunction

    task automatic drive(input bit rst, input logic [31:0] pc, input bit hit,
                         input logic [31:0] bta, input bit stall, input bit fd,
                         input bit fe, input bit br, input bit tk, input logic [31:0] alu);
        exp_t e;
        rec_t f;
        rec_t ne;
        int   idx;
        bit   misp;
        @(posedge clk);
        #1;
        reset                = rst;
        bif.pcF              = pc;
        bif.btbHit           = hit;
        bif.btbBTA           = bta;
        bif.stallD           = stall;
        bif.flushD           = fd;
        bif.flushE           = fe;
        bif.branchE          = br;
        bif.branchTakenE     = tk;
        bif.aluBranchAddress = alu;
        if (rst) model_reset();
        idx   = int'(pc[7:2]);
        e.ptf = hit && (pht_m[idx] >= 2);
        e.npc = e.ptf ? bta : pc + 32'd4;
        e.bpe = me.v && me.pt;
        misp  = 1'b0;
        if (me.v) begin
            if (br) misp = (tk != me.pt) || (tk && (alu != me.tgt));
            else    misp = me.pt;
        end
        e.misp  = misp;
        e.redir = misp ? ((br && tk) ? alu : me.p4) : 32'd0;
        e.br    = 16'(br_m);
        e.msp   = 16'(msp_m);
        exp_q.push_back(e);
        if (!rst) begin
            if (me.v && br) begin
                if (tk) pht_m[me.idx] = (pht_m[me.idx] == 3) ? 3 : pht_m[me.idx] + 1;
                else    pht_m[me.idx] = (pht_m[me.idx] == 0) ? 0 : pht_m[me.idx] - 1;
                if (br_m < 65535) br_m++;
            end
            if (misp && msp_m < 65535) msp_m++;
            f  = '{1'b1, e.ptf, bta, idx, pc + 32'd4};
            ne = me;
            if (misp || fe) ne.v = 1'b0;
            else            ne = md;
            if (misp || fd) md.v = 1'b0;
            else if (!stall) md = f;
            me = ne;
        end
    endtask

    // Monitor: one expectation per cycle, compared away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pcNextPred",       bif.pcNextPred,             e.npc);
                chk("predictTakenF",    32'(bif.predictTakenF),     32'(e.ptf));
                chk("branchPredictedE", 32'(bif.branchPredictedE),  32'(e.bpe));
                chk("mispredictE",      32'(bif.mispredictE),       32'(e.misp));
                chk("redirectPC",       bif.redirectPC,             e.redir);
                chk("brCount",          32'(bif.brCount),           32'(e.br));
                chk("mispCount",        32'(bif.mispCount),         32'(e.msp));
            end
        end
    end

    initial begin
        logic [31:0] pc, bta, alu;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        model_reset();
        // Reset, then the directed sequence.
        drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200);
        drive(1'b0, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200);
        drive(1'b0, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h300);
        drive(1'b0, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h108, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h10c, 1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h10c, 1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h10c, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'h10c, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h300);
        drive(1'b0, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        // Randomised traffic over a small, aliasing PC pool including the wrap point.
        for (int n = 0; n < 800; n++) begin
            case ($urandom_range(0, 5))
                0:       pc = 32'h100;
                1:       pc = 32'h104;
                2:       pc = 32'h108;
                3:       pc = 32'h1100;
                4:       pc = 32'hFFFF_FFFC;
                default: pc = {$urandom_range(0, 255), 2'b00};
            endcase
            bta = ($urandom_range(0, 1) == 0) ? 32'h200 : 32'h300;
            case ($urandom_range(0, 2))
                0:       alu = 32'h200;
                1:       alu = 32'h300;
                default: alu = $urandom;
            endcase
            drive(($urandom_range(0, 79) == 0), pc, ($urandom_range(0, 3) != 0), bta,
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 11) == 0), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 1) == 1), alu);
        end
        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
